tile_plot_scheduler: RTL

Sequences and arbitrates all tile pixel writes into the VGA adapter write port (RX/RY/colour/plot) for the tiles game. Four tile channels each request a "move": erase the tile's old rectangle, then draw it at its new position. A round-robin arbiter serves one channel at a time. A full-screen clear request takes priority at the next idle point. The block replaces per-tile ad hoc erase/draw sequencing with one owner of the framebuffer port.

---
 rtl/tile_plot_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/tile_plot_scheduler.sv
// tile_plot_scheduler: single owner of the VGA adapter write port for tile moves and screen clear.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   req[3:0]                  per-channel move request, held until ack
//   old_x/old_y, new_x/new_y  packed per-channel coordinates (8-bit X, 7-bit Y)
//   clear_req                 full-screen black clear request, held until clear_done
//   ack[3:0], clear_done      one-cycle completion pulses
//   busy                      high whenever the scheduler is not idle
//   RX, RY, colour, plot      registered pixel write to the VGA adapter
// Optional macro CLIP_EN: suppresses plot for pixels outside SCR_W x SCR_H.
module tile_plot_scheduler #(
    parameter int         TILE_W      = 40,
    parameter int         TILE_H      = 15,
    parameter logic [1:0] TILE_COLOUR = 2'b11,
    parameter int         SCR_W       = 160,
    parameter int         SCR_H       = 120
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] old_x,
    input  logic [27:0] old_y,
    input  logic [31:0] new_x,
    input  logic [27:0] new_y,
    input  logic        clear_req,
    output logic [3:0]  ack,
    output logic        clear_done,
    output logic        busy,
    output logic [7:0]  RX,
    output logic [6:0]  RY,
    output logic [1:0]  colour,
    output logic        plot
);
    typedef enum logic [2:0] {IDLE, CLEAR, ERASE, DRAW, ACK, CDONE} state_t;
`ifdef CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif
    localparam logic [7:0] TW1 = 8'(TILE_W - 1);
    localparam logic [6:0] TH1 = 7'(TILE_H - 1);
    localparam logic [7:0] SW1 = 8'(SCR_W - 1);
    localparam logic [6:0] SH1 = 7'(SCR_H - 1);

    state_t     r_state, w_next;
    logic [1:0] r_ptr, r_g, w_g;
    logic       w_any;
    logic [7:0] r_ox, r_nx, r_cx, w_cx, w_bx, w_lim_x;
    logic [6:0] r_oy, r_ny, r_cy, w_cy, w_by, w_lim_y;
    logic [8:0] w_sx;
    logic [7:0] w_sy;
    logic       w_lx, w_ly, w_pix, w_vis, w_last;

    always_comb begin
        w_g   = r_ptr;
        w_any = 1'b0;
        // descending scan so the closest set bit at or after r_ptr wins
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_g   = r_ptr + 2'(i);
                w_any = 1'b1;
            end
        end
        w_bx    = (r_state == DRAW) ? r_nx : (r_state == ERASE) ? r_ox : 8'd0;
        w_by    = (r_state == DRAW) ? r_ny : (r_state == ERASE) ? r_oy : 7'd0;
        w_lim_x = (r_state == CLEAR) ? SW1 : TW1;
        w_lim_y = (r_state == CLEAR) ? SH1 : TH1;
        w_sx    = {1'b0, w_bx} + {1'b0, r_cx};
        w_sy    = {1'b0, w_by} + {1'b0, r_cy};
        w_lx    = (r_cx == w_lim_x);
        w_ly    = (r_cy == w_lim_y);
        w_last  = w_lx && w_ly;
        w_pix   = (r_state == CLEAR) || (r_state == ERASE) || (r_state == DRAW);
        w_vis   = !CLIP || ((w_sx < 9'(SCR_W)) && (w_sy < 8'(SCR_H)));
        w_cx    = (w_pix && !w_lx) ? r_cx + 8'd1 : 8'd0;
        w_cy    = !w_pix ? 7'd0 : !w_lx ? r_cy : w_ly ? 7'd0 : r_cy + 7'd1;
        w_next  = r_state;
        case (r_state)
            IDLE:    w_next = clear_req ? CLEAR : w_any ? ERASE : IDLE;
            CLEAR:   w_next = w_last ? CDONE : CLEAR;
            ERASE:   w_next = w_last ? DRAW : ERASE;
            DRAW:    w_next = w_last ? ACK : DRAW;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= 2'd0;
            r_g        <= 2'd0;
            r_cx       <= 8'd0;
            r_cy       <= 7'd0;
            r_ox       <= 8'd0;
            r_oy       <= 7'd0;
            r_nx       <= 8'd0;
            r_ny       <= 7'd0;
            RX         <= 8'd0;
            RY         <= 7'd0;
            colour     <= 2'b00;
            plot       <= 1'b0;
            ack        <= 4'd0;
            clear_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cx    <= w_cx;
            r_cy    <= w_cy;
            if (r_state == IDLE && !clear_req && w_any) begin
                r_g  <= w_g;
                r_ox <= old_x[8*w_g +: 8];
                r_oy <= old_y[7*w_g +: 7];
                r_nx <= new_x[8*w_g +: 8];
                r_ny <= new_y[7*w_g +: 7];
            end
            if (r_state == ACK) r_ptr <= r_g + 2'd1;
            RX         <= w_sx[7:0];
            RY         <= w_sy[6:0];
            colour     <= (r_state == DRAW) ? TILE_COLOUR : 2'b00;
            plot       <= w_pix && w_vis;
            ack        <= (r_state == ACK) ? 4'b0001 << r_g : 4'd0;
            clear_done <= (r_state == CDONE);
            busy       <= (w_next != IDLE);
        end
    end
endmodule
